// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_sequencer
// Brief    : LED pattern sequencer. Steps an active-low pattern across N_LEDS
//            LEDs every TICK_CYCLES clocks while running. Three debounced
//            active-low buttons provide stop, start and mode-cycle control.
//            Modes: rotate-left, rotate-right, bounce (ping-pong).
// Revision : 1.0 - initial release
// ============================================================================
module led_sequencer #(
    parameter int                N_LEDS          = 3,
    parameter int                TICK_CYCLES     = 13_500_000,
    parameter int                DEBOUNCE_CYCLES = 270_000,
    parameter logic [N_LEDS-1:0] INIT_PATTERN    = {{(N_LEDS-1){1'b1}}, 1'b0}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_stop_n,
    input  logic              btn_start_n,
    input  logic              btn_mode_n,
    output logic [N_LEDS-1:0] led,
    output logic              running,
    output logic [1:0]        mode
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_TICK_W = $clog2(TICK_CYCLES);
    localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_POS_W  = $clog2(N_LEDS);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_POS_W-1:0]  c_POS_LAST  = c_POS_W'(N_LEDS - 1);

    // Run/stop state encoding
    localparam logic [0:0] c_ST_STOP = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Pattern mode encoding (2'b11 is never produced)
    localparam logic [1:0] c_MODE_ROTL   = 2'b00;
    localparam logic [1:0] c_MODE_ROTR   = 2'b01;
    localparam logic [1:0] c_MODE_BOUNCE = 2'b10;

    // Button lanes in the raw/press vectors
    localparam int c_BTN_STOP  = 0;
    localparam int c_BTN_START = 1;
    localparam int c_BTN_MODE  = 2;
    localparam int c_N_BTN     = 3;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [c_N_BTN-1:0]  w_btn_raw;
    logic [c_N_BTN-1:0]  w_press;
    logic                w_stop_ev;
    logic                w_start_ev;
    logic                w_mode_ev;

    logic [0:0]          r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [N_LEDS-1:0]   r_led;
    logic [c_POS_W-1:0]  r_pos;
    logic                r_dir_up;
    logic [1:0]          r_mode;

    logic                w_step;
    logic                w_step_left;
    logic [N_LEDS-1:0]   w_rotl;
    logic [N_LEDS-1:0]   w_rotr;
    logic [c_POS_W-1:0]  w_pos_inc;
    logic [c_POS_W-1:0]  w_pos_dec;
    logic [1:0]          w_mode_nxt;

    assign w_btn_raw = {btn_mode_n, btn_start_n, btn_stop_n};

    // ------------------------------------------------------------------------
    // Button conditioning: synchroniser, debounce filter, press detector.
    // Released level is 1; a press event fires once on the debounced 1->0.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < c_N_BTN; gi++) begin : g_btn
            logic              r_sync1;
            logic              r_sync2;
            logic              r_level;
            logic              r_level_d;
            logic [c_DB_W-1:0] r_db_cnt;

            // Two-stage synchroniser for the asynchronous button input.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // Debounce: the level follows the input only after it has
            // disagreed for DEBOUNCE_CYCLES consecutive clocks.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_db_cnt <= '0;
                    r_level  <= 1'b1;
                end else if (r_sync2 != r_level) begin
                    if (r_db_cnt == c_DB_LAST) begin
                        r_level  <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_DB_W'(1);
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end

            // Delayed debounced level, used to detect the falling edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_level_d <= 1'b1;
                end else begin
                    r_level_d <= r_level;
                end
            end

            assign w_press[gi] = r_level_d & ~r_level;
        end
    endgenerate

    assign w_stop_ev  = w_press[c_BTN_STOP];
    assign w_start_ev = w_press[c_BTN_START];
    assign w_mode_ev  = w_press[c_BTN_MODE];

    // ------------------------------------------------------------------------
    // Run/stop control
    // ------------------------------------------------------------------------

    // Run/stop state: a stop event overrides a simultaneous start event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_STOP;
        end else begin
            case (r_state)
                c_ST_STOP: if (w_start_ev && !w_stop_ev) r_state <= c_ST_RUN;
                c_ST_RUN:  if (w_stop_ev) r_state <= c_ST_STOP;
                default:   r_state <= c_ST_STOP;
            endcase
        end
    end

    // Tick counter advances only while running; it holds its value when
    // stopped so that a resume completes the interrupted interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
        end else if (r_state == c_ST_RUN) begin
            r_tick <= (r_tick == c_TICK_LAST) ? '0 : r_tick + c_TICK_W'(1);
        end
    end

    assign w_step = (r_state == c_ST_RUN) && (r_tick == c_TICK_LAST);

    // ------------------------------------------------------------------------
    // Pattern stepping
    // ------------------------------------------------------------------------
    assign w_rotl    = {r_led[N_LEDS-2:0], r_led[N_LEDS-1]};
    assign w_rotr    = {r_led[0], r_led[N_LEDS-1:1]};
    assign w_pos_inc = (r_pos == c_POS_LAST) ? '0 : r_pos + c_POS_W'(1);
    assign w_pos_dec = (r_pos == '0) ? c_POS_LAST : r_pos - c_POS_W'(1);

    // Step direction for the current mode; bounce follows the dir flag.
    always_comb begin
        w_step_left = 1'b1;
        case (r_mode)
            c_MODE_ROTL:   w_step_left = 1'b1;
            c_MODE_ROTR:   w_step_left = 1'b0;
            c_MODE_BOUNCE: w_step_left = r_dir_up;
            default:       w_step_left = 1'b1;
        endcase
    end

    // LED pattern and position move together on each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= INIT_PATTERN;
            r_pos <= '0;
        end else if (w_step) begin
            if (w_step_left) begin
                r_led <= w_rotl;
                r_pos <= w_pos_inc;
            end else begin
                r_led <= w_rotr;
                r_pos <= w_pos_dec;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Mode and bounce direction
    // ------------------------------------------------------------------------
    assign w_mode_nxt = (r_mode == c_MODE_BOUNCE) ? c_MODE_ROTL : r_mode + 2'd1;

    // Mode cycles on each mode event; a concurrent step still uses the old mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= c_MODE_ROTL;
        end else if (w_mode_ev) begin
            r_mode <= w_mode_nxt;
        end
    end

    // Bounce direction: seeded on entry to bounce from the current position,
    // then reversed whenever a bounce step lands on either end.
    // Entry into bounce can only coincide with a rotate-right step, so the
    // two branches never compete for the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_up <= 1'b1;
        end else if (w_mode_ev && (w_mode_nxt == c_MODE_BOUNCE)) begin
            r_dir_up <= (r_pos != c_POS_LAST);
        end else if (w_step && (r_mode == c_MODE_BOUNCE)) begin
            if (w_step_left && (w_pos_inc == c_POS_LAST)) begin
                r_dir_up <= 1'b0;
            end else if (!w_step_left && (w_pos_dec == '0)) begin
                r_dir_up <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign led     = r_led;
    assign running = (r_state == c_ST_RUN);
    assign mode    = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_sequencer
// Brief    : Self-checking bench for led_sequencer. A behavioural model tracks
//            LED position, mode and run state from button activity; the LED
//            word is derived as the reset pattern rotated left by position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

    localparam int         N    = 4;
    localparam int         T    = 4;
    localparam int         DEB  = 3;
    localparam logic [3:0] INIT = 4'b1110;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b1;
    logic       btn_stop_n  = 1'b1;
    logic       btn_start_n = 1'b1;
    logic       btn_mode_n  = 1'b1;
    logic [3:0] led;
    logic       running;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    led_sequencer #(
        .N_LEDS          (N),
        .TICK_CYCLES     (T),
        .DEBOUNCE_CYCLES (DEB),
        .INIT_PATTERN    (INIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_stop_n  (btn_stop_n),
        .btn_start_n (btn_start_n),
        .btn_mode_n  (btn_mode_n),
        .led         (led),
        .running     (running),
        .mode        (mode)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural model. Button lanes: 0 stop, 1 start, 2 mode.
    // ------------------------------------------------------------------------
    bit m_s1   [3];
    bit m_s2   [3];
    bit m_lvl  [3];
    bit m_prev [3];
    bit m_hist [3][DEB];
    int m_hcnt [3];
    int m_pos;
    int m_tick;
    int m_mode;
    bit m_up;
    bit m_run;

    function automatic logic [3:0] led_at(input int p);
        logic [3:0] v;
        v = INIT;
        for (int k = 0; k < p; k++) v = {v[2:0], v[3]};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_s1[i]   = 1'b1;
            m_s2[i]   = 1'b1;
            m_lvl[i]  = 1'b1;
            m_prev[i] = 1'b1;
            m_hcnt[i] = 0;
        end
        m_pos  = 0;
        m_tick = 0;
        m_mode = 0;
        m_up   = 1'b1;
        m_run  = 1'b0;
    endtask

    task automatic model_edge();
        bit raw   [3];
        bit press [3];
        bit flip;
        bit step;
        bit left;
        int old_pos;
        raw[0] = btn_stop_n;
        raw[1] = btn_start_n;
        raw[2] = btn_mode_n;
        for (int i = 0; i < 3; i++) press[i] = m_prev[i] && !m_lvl[i];
        // A debounced level flips once its last DEB synchronised samples all disagree.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < DEB - 1; k++) m_hist[i][k] = m_hist[i][k+1];
            m_hist[i][DEB-1] = m_s2[i];
            if (m_hcnt[i] < DEB) m_hcnt[i]++;
            flip = (m_hcnt[i] == DEB);
            for (int k = 0; k < DEB; k++) if (m_hist[i][k] == m_lvl[i]) flip = 1'b0;
            m_prev[i] = m_lvl[i];
            if (flip) m_lvl[i] = !m_lvl[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        old_pos = m_pos;
        step    = m_run && (m_tick == T - 1);
        if (m_run) m_tick = (m_tick + 1) % T;
        if (step) begin
            left  = (m_mode == 0) || ((m_mode == 2) && m_up);
            m_pos = left ? (m_pos + 1) % N : (m_pos + N - 1) % N;
            if (m_mode == 2) begin
                if (m_pos == N - 1) m_up = 1'b0;
                else if (m_pos == 0) m_up = 1'b1;
            end
        end
        if (press[2]) begin
            m_mode = (m_mode + 1) % 3;
            if (m_mode == 2) m_up = (old_pos != N - 1);
        end
        if (m_run && press[0]) m_run = 1'b0;
        else if (!m_run && press[1] && !press[0]) m_run = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Literal LED expectation applied to both the DUT and the model.
    task automatic lit_led(input string name, input logic [3:0] exp);
        check(name, 32'(led), 32'(exp));
        check({name, "_model"}, 32'(led_at(m_pos)), 32'(exp));
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_led",     32'(led),     32'(led_at(m_pos)));
        check("cyc_running", 32'(running), 32'(m_run));
        check("cyc_mode",    32'(mode),    32'(m_mode));
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step_clk();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic clk_n(input int n);
        repeat (n) step_clk();
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_stop_n  = v;
            1:       btn_start_n = v;
            default: btn_mode_n  = v;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        set_btn(which, 1'b0);
        clk_n(hold);
        set_btn(which, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        clk_n(3);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        logic [3:0] bounce_seq [7];
        bounce_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101};

        model_reset();
        #1;
        do_reset();
        lit_led("reset_led", 4'b1110);
        check("reset_running", 32'(running), 32'd0);
        check("reset_mode", 32'(mode), 32'd0);

        // Start held: running rises on the sixth clock, then ROTL steps every 4.
        btn_start_n = 1'b0;
        clk_n(5);
        check("start_lat_lo", 32'(running), 32'd0);
        clk_n(1);
        check("start_lat_hi", 32'(running), 32'd1);
        clk_n(4);
        lit_led("rotl_1", 4'b1101);
        btn_start_n = 1'b1;
        clk_n(4);
        lit_led("rotl_2", 4'b1011);
        clk_n(4);
        lit_led("rotl_3", 4'b0111);
        clk_n(4);
        lit_led("rotl_wrap", 4'b1110);

        // Stop and start together while running: stop wins.
        btn_stop_n  = 1'b0;
        btn_start_n = 1'b0;
        clk_n(6);
        btn_stop_n  = 1'b1;
        btn_start_n = 1'b1;
        check("both_run_stops", 32'(running), 32'd0);
        clk_n(8);

        // Stop and start together while stopped: stays stopped.
        btn_stop_n  = 1'b0;
        btn_start_n = 1'b0;
        clk_n(6);
        btn_stop_n  = 1'b1;
        btn_start_n = 1'b1;
        clk_n(4);
        check("both_stop_stays", 32'(running), 32'd0);
        clk_n(4);

        // Glitchy start: two 2-clock lows separated by one high clock.
        press(1, 2);
        clk_n(1);
        press(1, 2);
        clk_n(10);
        check("glitch_no_start", 32'(running), 32'd0);
        // Minimal stable press registers.
        press(1, 3);
        clk_n(2);
        check("min_press_lo", 32'(running), 32'd0);
        clk_n(1);
        check("min_press_hi", 32'(running), 32'd1);
        clk_n(8);

        // Pause mid-tick, change mode while stopped, resume with held tick.
        do_reset();
        press(1, 6);
        check("t3_running", 32'(running), 32'd1);
        clk_n(4);
        lit_led("t3_step1", 4'b1101);
        btn_stop_n = 1'b0;
        clk_n(4);
        lit_led("t3_step2", 4'b1011);
        clk_n(2);
        btn_stop_n = 1'b1;
        check("t3_stopped", 32'(running), 32'd0);
        clk_n(10);
        lit_led("t3_frozen", 4'b1011);
        // A long hold yields exactly one mode event.
        press(2, 12);
        check("t4_mode_once", 32'(mode), 32'd1);
        clk_n(8);
        check("t4_mode_held", 32'(mode), 32'd1);
        press(1, 6);
        check("t3_resumed", 32'(running), 32'd1);
        clk_n(1);
        lit_led("t3_resume_wait", 4'b1011);
        clk_n(1);
        lit_led("t4_rotr_1", 4'b1101);
        clk_n(4);
        lit_led("t4_rotr_2", 4'b1110);
        clk_n(4);
        lit_led("t4_rotr_3", 4'b0111);

        // Bounce from the reset pattern.
        do_reset();
        press(2, 6);
        check("t5_mode1", 32'(mode), 32'd1);
        clk_n(8);
        press(2, 6);
        check("t5_mode2", 32'(mode), 32'd2);
        clk_n(8);
        press(1, 6);
        check("t5_running", 32'(running), 32'd1);
        for (int s = 0; s < 7; s++) begin
            clk_n(4);
            lit_led($sformatf("bounce_%0d", s), bounce_seq[s]);
        end

        // Asynchronous reset mid-run takes effect without a clock edge.
        clk_n(2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        lit_led("async_rst_led", 4'b1110);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_mode", 32'(mode), 32'd0);
        clk_n(3);
        rst_n = 1'b1;
        clk_n(5);
        check("post_rst_idle", 32'(running), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
